// File: rtl/sram_arb_pkg.sv
// Shared constants and types for the data-SRAM arbiter.
package sram_arb_pkg;
    localparam int SRAM_DEPTH    = 2048;
    localparam int SRAM_AW       = 11;
    localparam int DW            = 8;
    localparam int CORE_AW       = 12;
    localparam int DATA_BASE_DEF = 256;

    typedef enum logic {NORMAL = 1'b0, STEAL = 1'b1} arb_state_t;

    // One macro access as seen by the mux: chip select, write, address, data.
    typedef struct packed {
        logic               cs;
        logic               we;
        logic [SRAM_AW-1:0] a;
        logic [DW-1:0]      d;
    } sram_cmd_t;
endpackage

// File: rtl/sram_arbiter_if.sv
// Secondary (DMA/debug) requester port of the data-SRAM arbiter.
interface sram_arbiter_if;
    import sram_arb_pkg::*;
    logic               req;
    logic               we;
    logic [SRAM_AW-1:0] adr;
    logic [DW-1:0]      wdata;
    logic               gnt;
    logic               rvalid;
    logic [DW-1:0]      rdata;

    modport master (output req, we, adr, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, adr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/sram_arb_starve_ctr.sv
// Saturating DMA wait counter; raises steal_req on the last tolerated wait cycle.
module sram_arb_starve_ctr #(
    parameter int STARVE_MAX = 16
) (
    input  logic clk,
    input  logic ireset,
    input  logic dma_req,
    input  logic dma_gnt,
    output logic steal_req
);
    logic [7:0] cnt;

    always_ff @(posedge clk or posedge ireset) begin
        if (ireset)                 cnt <= 8'd0;
        else if (!dma_req || dma_gnt) cnt <= 8'd0;
        else if (cnt != 8'(STARVE_MAX)) cnt <= cnt + 8'd1;
    end

    assign steal_req = dma_req & ~dma_gnt & (cnt == 8'(STARVE_MAX - 1));
endmodule

// File: rtl/sram_arbiter.sv
// Data-SRAM arbiter: core has zero-wait priority, DMA takes idle cycles.
// Define SRAM_ARB_STARVE_EN to add the starvation counter and core-freezing STEAL slot.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int STARVE_MAX = 16,
    parameter int DATA_BASE  = DATA_BASE_DEF
) (
    input  logic               clk,
    input  logic               ireset,
    input  logic               core_re,
    input  logic               core_we,
    input  logic [CORE_AW-1:0] core_adr,
    input  logic [DW-1:0]      core_wdata,
    output logic [DW-1:0]      core_rdata,
    output logic               core_stall,
    sram_arbiter_if.slave      dma,
    output logic               sram_cen,
    output logic               sram_wen,
    output logic [SRAM_AW-1:0] sram_a,
    output logic [DW-1:0]      sram_d,
    input  logic [DW-1:0]      sram_q
);
    logic [CORE_AW:0]   core_adr_x;
    logic               core_hit;
    logic [SRAM_AW-1:0] core_sa;
    arb_state_t         state;
    logic               gnt;
    sram_cmd_t          cmd;
    logic [SRAM_AW-1:0] a_q;
    logic [DW-1:0]      d_q;
    logic [1:0]         vld_pipe;
    logic [DW-1:0]      rdata_q;

    assign core_adr_x = {1'b0, core_adr};
    assign core_hit   = (core_re | core_we)
                      && (core_adr_x >= 13'(DATA_BASE))
                      && (core_adr_x <  13'(DATA_BASE + SRAM_DEPTH));
    // Subtracting in 11 bits gives the same word as a full subtract then truncate.
    assign core_sa    = core_adr[SRAM_AW-1:0] - 11'(DATA_BASE);

`ifdef SRAM_ARB_STARVE_EN
    arb_state_t state_nxt;
    logic       steal_req;

    sram_arb_starve_ctr #(.STARVE_MAX(STARVE_MAX)) u_starve_ctr (
        .clk       (clk),
        .ireset    (ireset),
        .dma_req   (dma.req),
        .dma_gnt   (gnt),
        .steal_req (steal_req)
    );

    always_ff @(posedge clk or posedge ireset) begin
        if (ireset) state <= NORMAL;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = NORMAL;
        case (state)
            NORMAL:  if (steal_req) state_nxt = STEAL;
            STEAL:   state_nxt = NORMAL;
            default: state_nxt = NORMAL;
        endcase
    end
`else
    assign state = NORMAL;
`endif

    always_comb begin
        gnt = 1'b0;
        cmd = '0;
        if (!ireset) begin
            if (state == STEAL) gnt = dma.req;
            else                gnt = dma.req & ~core_hit;
        end
        if (gnt)
            cmd = '{cs: 1'b1, we: dma.we, a: dma.adr, d: dma.wdata};
        else if (core_hit && state != STEAL && !ireset)
            cmd = '{cs: 1'b1, we: core_we, a: core_sa, d: core_wdata};
    end

    // Idle cycles keep the previous address/data on the macro pins.
    always_ff @(posedge clk or posedge ireset) begin
        if (ireset) begin
            a_q <= '0;
            d_q <= '0;
        end else if (cmd.cs) begin
            a_q <= cmd.a;
            d_q <= cmd.d;
        end
    end

    assign sram_cen = ~cmd.cs;
    assign sram_wen = ~(cmd.cs & cmd.we);
    assign sram_a   = cmd.cs ? cmd.a : a_q;
    assign sram_d   = cmd.cs ? cmd.d : d_q;

    assign vld_pipe[0] = gnt & ~dma.we;
    always_ff @(posedge clk or posedge ireset) begin
        if (ireset) begin
            vld_pipe[1] <= 1'b0;
            rdata_q     <= '0;
        end else begin
            vld_pipe[1] <= vld_pipe[0];
            if (vld_pipe[0]) rdata_q <= sram_q;
        end
    end

    assign dma.gnt    = gnt;
    assign dma.rvalid = vld_pipe[1];
    assign dma.rdata  = rdata_q;
    assign core_rdata = sram_q;
    assign core_stall = (state == STEAL);
endmodule
